// File: rtl/prog_lut_sweep.sv
// prog_lut_sweep
//   Serially programmable 2^N-entry, 1-bit lookup table. The table is loaded
//   one bit per cycle through a shift register. It can be evaluated one index
//   at a time, or swept over every index with a running count of 1 entries.
//
//   Ports
//     clk         : sole clock, rising edge
//     rst         : synchronous active-high reset
//     cfg_en      : shift cfg_bit into the table this cycle; aborts a sweep
//     cfg_bit     : bit shifted into table[W-1]
//     in          : evaluation index
//     in_vld      : evaluate table[in] this cycle
//     sweep_start : start a sweep of indices 0..W-1
//     out         : registered table value
//     out_idx     : index that produced out
//     out_vld     : out/out_idx valid this cycle
//     busy        : sweep in progress
//     done        : one-cycle pulse alongside the last sweep output
//     ones_cnt    : number of 1 entries found by the last completed sweep
//
//   state  | meaning
//   S_IDLE | accepts cfg shifts, sweep_start and single evaluations
//   S_RUN  | emitting sweep index cnt_q on each edge
//   S_TAIL | last index emitted; one more busy cycle, then back to idle
module prog_lut_sweep #(
  parameter int              N    = 4,
  parameter logic [2**N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_bit,
  input  logic [N-1:0] in,
  input  logic         in_vld,
  input  logic         sweep_start,
  output logic         out,
  output logic [N-1:0] out_idx,
  output logic         out_vld,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_cnt
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_TAIL
  } state_t;

  state_t         state_q;
  logic [W-1:0]   table_q;
  logic [W-1:0]   table_d;
  logic           out_q;
  logic [N-1:0]   out_idx_q;
  logic           out_vld_q;
  logic           done_q;
  logic [N:0]     ones_cnt_q;
  logic [N-1:0]   cnt_q;
  logic [N:0]     acc_q;
  logic [N:0]     acc_d;
  logic           last_idx;

  // New bits enter at the top so that after W shifts the first bit lands in table[0].
  assign table_d  = {cfg_bit, table_q[W-1:1]};
  assign acc_d    = acc_q + {{N{1'b0}}, table_q[cnt_q]};
  assign last_idx = (cnt_q == N'(W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      table_q    <= INIT;
      out_q      <= 1'b0;
      out_idx_q  <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      ones_cnt_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
    end else begin
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      if (cfg_en) begin
        // A shift during a sweep abandons it; ones_cnt keeps the last completed result.
        table_q <= table_d;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sweep_start) begin
              out_q     <= table_q[0];
              out_idx_q <= '0;
              out_vld_q <= 1'b1;
              cnt_q     <= N'(1);
              acc_q     <= {{N{1'b0}}, table_q[0]};
              state_q   <= S_RUN;
            end else if (in_vld) begin
              out_q     <= table_q[in];
              out_idx_q <= in;
              out_vld_q <= 1'b1;
            end
          end
          S_RUN: begin
            out_q     <= table_q[cnt_q];
            out_idx_q <= cnt_q;
            out_vld_q <= 1'b1;
            acc_q     <= acc_d;
            if (last_idx) begin
              done_q     <= 1'b1;
              ones_cnt_q <= acc_d;
              state_q    <= S_TAIL;
            end else begin
              cnt_q <= cnt_q + N'(1);
            end
          end
          S_TAIL: begin
            // Requests arriving here were seen while busy and are dropped.
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign out      = out_q;
  assign out_idx  = out_idx_q;
  assign out_vld  = out_vld_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign ones_cnt = ones_cnt_q;

endmodule

// File: tb/tb_prog_lut_sweep.sv
module tb_prog_lut_sweep;

  localparam int              N    = 4;
  localparam int              W    = 16;
  localparam logic [W-1:0]    INIT = 16'h9A0C;

  logic         clk = 1'b0;
  logic         rst, cfg_en, cfg_bit, in_vld, sweep_start;
  logic [N-1:0] in_s;
  logic         out_s, out_vld, busy, done;
  logic [N-1:0] out_idx;
  logic [N:0]   ones_cnt;

  int total = 0;
  int bad   = 0;

  prog_lut_sweep #(.N(N), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_bit(cfg_bit),
    .in(in_s), .in_vld(in_vld), .sweep_start(sweep_start),
    .out(out_s), .out_idx(out_idx), .out_vld(out_vld),
    .busy(busy), .done(done), .ones_cnt(ones_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: table as a plain bit vector, sweep as a position
  // (-1 idle, 0..W-1 next index to emit, W = final busy cycle).
  logic [W-1:0] m_tbl;
  logic         m_out, m_vld, m_done;
  int           m_idx, m_ones, m_pos, m_snap;

  task automatic model_step(input logic r, ce, cb, ss, iv, input int ix);
    if (r) begin
      m_tbl = INIT; m_out = 0; m_idx = 0; m_vld = 0; m_done = 0;
      m_ones = 0; m_pos = -1;
    end else if (ce) begin
      m_tbl = {cb, m_tbl[W-1:1]};
      m_vld = 0; m_done = 0; m_pos = -1;
    end else if (m_pos >= 0) begin
      if (m_pos < W) begin
        m_out = m_tbl[m_pos]; m_idx = m_pos; m_vld = 1;
        m_done = (m_pos == W-1);
        if (m_done) m_ones = m_snap;
        m_pos++;
      end else begin
        m_vld = 0; m_done = 0; m_pos = -1;
      end
    end else if (ss) begin
      m_out = m_tbl[0]; m_idx = 0; m_vld = 1; m_done = 0;
      m_pos = 1; m_snap = $countones(m_tbl);
    end else if (iv) begin
      m_out = m_tbl[ix]; m_idx = ix; m_vld = 1; m_done = 0;
    end else begin
      m_vld = 0; m_done = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, ce, cb, ss, iv, input int ix);
    rst = r; cfg_en = ce; cfg_bit = cb; sweep_start = ss; in_vld = iv;
    in_s = N'(ix);
    @(posedge clk);
    model_step(r, ce, cb, ss, iv, ix);
    #1;
    chk("model_out_vld", 32'(out_vld), 32'(m_vld));
    if (m_vld) begin
      chk("model_out", 32'(out_s), 32'(m_out));
      chk("model_out_idx", 32'(out_idx), 32'(m_idx));
    end
    chk("model_busy", 32'(busy), 32'(m_pos >= 0));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_ones_cnt", 32'(ones_cnt), 32'(m_ones));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int   ix;
    logic exp;
  } vec_t;

  vec_t         vecs[4];
  logic [W-1:0] pat;

  initial begin
    vecs[0] = '{0, 1'b1};
    vecs[1] = '{1, 1'b1};
    vecs[2] = '{2, 1'b0};
    vecs[3] = '{15, 1'b1};
    pat = 16'hA5C3;
    rst = 0; cfg_en = 0; cfg_bit = 0; sweep_start = 0; in_vld = 0; in_s = '0;
    m_tbl = INIT; m_out = 0; m_idx = 0; m_vld = 0; m_done = 0;
    m_ones = 0; m_pos = -1; m_snap = 0;

    // reset then a single evaluation
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ones", 32'(ones_cnt), 0);
    step(0, 0, 0, 0, 1, 5);
    chk("rst_eval_out", 32'(out_s), 0);
    chk("rst_eval_idx", 32'(out_idx), 5);
    chk("rst_eval_vld", 32'(out_vld), 1);

    // load A5C3 LSB-first and evaluate a few indices
    for (int i = 0; i < W; i++) step(0, 1, pat[i], 0, 0, 0);
    chk("load_vld", 32'(out_vld), 0);
    for (int v = 0; v < 4; v++) begin
      step(0, 0, 0, 0, 1, vecs[v].ix);
      chk("eval_out", 32'(out_s), 32'(vecs[v].exp));
      chk("eval_idx", 32'(out_idx), 32'(vecs[v].ix));
      chk("eval_vld", 32'(out_vld), 1);
    end
    idle();

    // full sweep
    step(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < W; k++) begin
      if (k > 0) idle();
      chk("sweep_idx", 32'(out_idx), 32'(k));
      chk("sweep_vld", 32'(out_vld), 1);
      chk("sweep_out", 32'(out_s), 32'(pat[k]));
      chk("sweep_done", 32'(done), 32'(k == W-1));
      if (k == W-1) chk("sweep_ones", 32'(ones_cnt), 8);
    end
    idle();
    chk("sweep_end_busy", 32'(busy), 0);
    chk("sweep_end_vld", 32'(out_vld), 0);
    chk("sweep_end_done", 32'(done), 0);

    // abort at index 6
    step(0, 0, 0, 1, 0, 0);
    repeat (6) idle();
    chk("abort_at_idx", 32'(out_idx), 6);
    step(0, 1, 0, 0, 0, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vld", 32'(out_vld), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ones", 32'(ones_cnt), 8);
    step(0, 0, 0, 0, 1, 1);
    chk("abort_shift_out", 32'(out_s), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("abort_shift_out0", 32'(out_s), 1);

    // collisions: start + in_vld together, then requests while busy
    step(0, 0, 0, 1, 1, 3);
    chk("coll_first_idx", 32'(out_idx), 0);
    for (int k = 1; k < W; k++) begin
      step(0, 0, 0, k[0], 1, 3);
      chk("coll_idx", 32'(out_idx), 32'(k));
      chk("coll_vld", 32'(out_vld), 1);
    end
    step(0, 0, 0, 1, 1, 3);
    chk("coll_tail_vld", 32'(out_vld), 0);
    chk("coll_tail_busy", 32'(busy), 0);
    chk("coll_ones", 32'(ones_cnt), 32'($countones(m_tbl)));

    // reset mid-sweep at index 9
    step(0, 0, 0, 1, 0, 0);
    repeat (9) idle();
    chk("rst_mid_at_idx", 32'(out_idx), 9);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_vld", 32'(out_vld), 0);
    chk("rst_mid_ones", 32'(ones_cnt), 0);
    step(0, 0, 0, 0, 1, 2);
    chk("rst_mid_init2", 32'(out_s), 1);
    step(0, 0, 0, 0, 1, 5);
    chk("rst_mid_init5", 32'(out_s), 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(199, 0) == 0),
           ($urandom_range(9, 0) == 0),
           1'($urandom),
           ($urandom_range(14, 0) == 0),
           ($urandom_range(1, 0) == 0),
           int'($urandom_range(W-1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_lut_sweep.md
PROG_LUT_SWEEP -- requirements
Module: prog_lut_sweep

Interface
REQ-001 SHALL have parameter N, default 4: number of LUT select inputs. Table depth W = 2^N.
REQ-002 SHALL have parameter INIT, default 0, width W: table contents after reset.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_en, input, 1 bit: shift one table bit this cycle.
REQ-006 SHALL have port cfg_bit, input, 1 bit: table bit shifted in when cfg_en=1.
REQ-007 SHALL have port in, input, N bits: evaluation select, {MSB..LSB} = table index.
REQ-008 SHALL have port in_vld, input, 1 bit: evaluate in this cycle.
REQ-009 SHALL have port sweep_start, input, 1 bit: start exhaustive sweep of all W indices.
REQ-010 SHALL have port out, output, 1 bit: registered table value.
REQ-011 SHALL have port out_idx, output, N bits: index that produced out.
REQ-012 SHALL have port out_vld, output, 1 bit: out/out_idx valid this cycle.
REQ-013 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse with the last sweep output.
REQ-015 SHALL have port ones_cnt, output, N+1 bits: number of 1 entries counted by the last completed sweep.

Function
REQ-016 SHALL resolve per-cycle priority as: rst > cfg_en > sweep (start or in progress) > in_vld.
REQ-017 SHALL, on each edge with cfg_en=1, update table <= {cfg_bit, table[W-1:1]}, so W consecutive shifts leave the first-shifted bit in table[0]; partial loads only shift.
REQ-018 SHALL, on an edge with cfg_en=1, force out_vld=0 and done=0.
REQ-019 SHALL, on an edge with cfg_en=1 while busy=1, abort the sweep: busy=0, no done pulse, ones_cnt unchanged.
REQ-020 SHALL, on an edge with in_vld=1 and no higher-priority event, register out=table[in], out_idx=in, out_vld=1, giving a latency of 1 cycle.
REQ-021 SHALL register out_vld=0 on any edge with no evaluation and no sweep output; out and out_idx then hold their previous values.
REQ-022 SHALL, on an edge with sweep_start=1, busy=0 and cfg_en=0, start a sweep: busy=1, out=table[0], out_idx=0, out_vld=1, internal counter=1, internal accumulator=table[0].
REQ-023 SHALL, on each following edge while busy=1, emit the counter index k: out=table[k], out_idx=k, out_vld=1, accumulator += table[k].
REQ-024 SHALL emit sweep outputs for indices 0..W-1 on W consecutive cycles, with no gaps.
REQ-025 SHALL, on the edge emitting index W-1, set done=1 and ones_cnt=final accumulator; the count is W when all entries are 1, and the N+1 width prevents overflow.
REQ-026 SHALL, on the edge after index W-1 is emitted, set busy=0, done=0 and out_vld=0.
REQ-027 SHALL ignore sweep_start and in_vld on every edge where busy=1 before that edge; the request is dropped, not queued.
REQ-028 SHALL give sweep_start precedence when sweep_start=1 and in_vld=1 on the same idle edge; in_vld is dropped.
REQ-029 SHALL keep done high for exactly one cycle per completed sweep.
REQ-030 SHALL change ones_cnt only at sweep completion or reset.

Reset
REQ-031 SHALL, on an edge with rst=1, set table=INIT, out=0, out_idx=0, out_vld=0, busy=0, done=0, ones_cnt=0, counter=0, accumulator=0.
REQ-032 SHALL, when rst=1 mid-sweep or mid-load, discard all progress; the next cycle behaves as post-reset idle.
REQ-033 SHALL apply rst with no dependence on any other input.

Verification (N=4)
REQ-034 SHALL cover reset: rst=1 for 2 cycles, then in=5 with in_vld=1 -> next cycle out=0, out_idx=5, out_vld=1; busy=0, done=0, ones_cnt=0.
REQ-035 SHALL cover load and evaluate: shift 16'hA5C3 LSB-first over 16 cfg_en cycles, then evaluate in=0,1,2,15 -> out=1,1,0,1, each one cycle after in_vld.
REQ-036 SHALL cover sweep: with table 16'hA5C3, pulse sweep_start -> 16 consecutive out_vld cycles with out_idx=0..15 and out matching the table bits; done=1 only with out_idx=15; ones_cnt=8 from that edge; busy=0 and out_vld=0 one cycle later.
REQ-037 SHALL cover abort: during the sweep, assert cfg_en (cfg_bit=0) while out_idx=6 -> next cycle busy=0, out_vld=0, no done; ones_cnt keeps its prior value; table shifted by one bit.
REQ-038 SHALL cover collisions: sweep_start and in_vld=1 (in=3) on the same idle edge -> the first output has out_idx=0, not 3; in_vld pulsed during busy -> no extra output and sweep indices stay contiguous.
REQ-039 SHALL cover reset mid-sweep: rst=1 while out_idx=9 -> next cycle busy=0, done=0, out_vld=0, ones_cnt=0, table=INIT.
